// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types and 7-segment glyph constants for the tug-of-war scoreboard
package tow_pkg;

  typedef enum logic [1:0] {PLAY, HOLD, MATCH_OVER} tow_state_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low segment patterns (bit 6 = g ... bit 0 = a) for decimal digits 0..9
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - combinational 4-bit value to active-low 7-segment glyph decoder
module seg7_digit
  import tow_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (value < 4'd10) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/tow_match_scoreboard.sv
// rtl/tow_match_scoreboard.sv - round-win detector, per-player score and match latch
// Optional winner-digit blink is enabled by defining TOW_BLINK_WINNER_EN.
module tow_match_scoreboard
  import tow_pkg::*;
#(
  parameter int WIN_TARGET   = 3,
  parameter int HOLD_CYCLES  = 8,
  parameter int BLINK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       L,
  input  logic       R,
  input  logic       lightLeft,
  input  logic       lightRight,
  output logic       round_reset,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [6:0] HEX_L,
  output logic [6:0] HEX_R
);

  localparam int SW = $clog2(WIN_TARGET + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (WIN_TARGET < 1 || WIN_TARGET > 9) begin : g_bad_target
    $error("WIN_TARGET must be in 1..9");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (BLINK_CYCLES < 1) begin : g_bad_blink
    $error("BLINK_CYCLES must be >= 1");
  end

  tow_state_e    state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] score_l, score_r;
  logic [SW-1:0] inc_l, inc_r, ev_score;
  logic [6:0]    glyph_inc_l, glyph_inc_r;
  logic          win_l, win_r;

`ifdef TOW_BLINK_WINNER_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
`endif

  assign win_l    = lightLeft  & L & ~R;
  assign win_r    = lightRight & R & ~L;
  assign inc_l    = score_l + 1'b1;
  assign inc_r    = score_r + 1'b1;
  assign ev_score = win_l ? inc_l : inc_r;

  // Decode the post-increment score so the digit lands on the same edge as the score
  seg7_digit u_seg_l (.value(4'(inc_l)), .seg(glyph_inc_l));
  seg7_digit u_seg_r (.value(4'(inc_r)), .seg(glyph_inc_r));

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= PLAY;
      hold_cnt    <= '0;
      score_l     <= '0;
      score_r     <= '0;
      round_reset <= 1'b0;
      match_over  <= 1'b0;
      winner      <= WIN_NONE;
      HEX_L       <= SEG_DIGIT[0];
      HEX_R       <= SEG_DIGIT[0];
`ifdef TOW_BLINK_WINNER_EN
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
`endif
    end else begin
      case (state)
        PLAY: begin
          if (win_l) begin
            score_l <= inc_l;
            HEX_L   <= glyph_inc_l;
          end else if (win_r) begin
            score_r <= inc_r;
            HEX_R   <= glyph_inc_r;
          end
          if (win_l || win_r) begin
            round_reset <= 1'b1;
            if (ev_score == SW'(WIN_TARGET)) begin
              state      <= MATCH_OVER;
              match_over <= 1'b1;
              winner     <= win_l ? WIN_P2 : WIN_P1;
`ifdef TOW_BLINK_WINNER_EN
              blink_cnt  <= '0;
              blink_off  <= 1'b0;
`endif
            end else begin
              state    <= HOLD;
              hold_cnt <= HW'(HOLD_CYCLES - 1);
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state       <= PLAY;
            round_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        MATCH_OVER: begin
          state <= MATCH_OVER;
`ifdef TOW_BLINK_WINNER_EN
          // Winner's score is necessarily WIN_TARGET here, so its glyph is a constant
          if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
            if (winner == WIN_P2) HEX_L <= blink_off ? SEG_DIGIT[WIN_TARGET] : SEG_OFF;
            else                  HEX_R <= blink_off ? SEG_DIGIT[WIN_TARGET] : SEG_OFF;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state       <= PLAY;
          round_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tow_match_scoreboard.md
Name: tow_match_scoreboard

Overview:
Next-generation win detector for the tug-of-war game. It detects round wins at either end of the light bar and keeps a per-player score. It shows each score on its own 7-segment display and holds the playfield in reset between rounds. It latches the match winner once a player reaches a parametrised target. Sits between the playfield (light chain, key conditioners) and the HEX displays in the top level.

Parameters:
WIN_TARGET, 3, round wins needed to win the match; legal range 1..9 (elaboration error otherwise)
HOLD_CYCLES, 8, cycles the playfield is held in reset after each round win; must be >= 1
BLINK_CYCLES, 16, half-period of the winner-digit blink (used only with the optional feature)

Ports:
clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
L  in  1  left key press, one-cycle pulse from the key conditioner
R  in  1  right key press, one-cycle pulse from the key conditioner
lightLeft  in  1  leftmost playfield light lit
lightRight  in  1  rightmost playfield light lit
round_reset  out  1  holds the playfield at centre while high
match_over  out  1  high once a match winner is latched
winner  out  2  00 none, 01 right player (P1), 10 left player (P2)
HEX_L  out  7  left-player score digit, active-low segments
HEX_R  out  7  right-player score digit, active-low segments

Behaviour:
- Reset values: state PLAY; score_l = score_r = 0; round_reset = 0; match_over = 0; winner = 00.
- Reset values (displays): HEX_L = HEX_R = glyph "0" (7'b1000000).
- All outputs are registered. Reset overrides everything, including mid-HOLD and MATCH_OVER.
- Left win event: lightLeft & L & ~R.
- Right win event: lightRight & R & ~L.
- The two events are mutually exclusive. L&R together is never a win.
- States:
  - PLAY: on a left event, score_l+1; on a right event, score_r+1. On either event, round_reset goes high.
  - PLAY, after an event: if the new score == WIN_TARGET, go to MATCH_OVER. Otherwise go to HOLD and load hold_cnt = HOLD_CYCLES-1.
  - PLAY, no event: stay in PLAY.
  - HOLD: round_reset = 1 and all key/light inputs are ignored. hold_cnt decrements each cycle.
  - HOLD, at hold_cnt == 0: go to PLAY with round_reset = 0 on the next cycle. round_reset is therefore high for exactly HOLD_CYCLES cycles.
  - MATCH_OVER: round_reset = 1, match_over = 1, winner set. The state is terminal until Reset and all inputs are ignored.
- Latency: the score, HEX digit, round_reset and match_over/winner all update on the clock edge that samples the event.
- Scores are $clog2(WIN_TARGET+1) bits wide and never exceed WIN_TARGET (no wrap).
- HEX digits: the decimal glyph of the score, 0..9, active-low.
- Unreachable state encodings recover to PLAY.

Optional Feature:
- Macro: TOW_BLINK_WINNER_EN.
- Defined: in MATCH_OVER the winner's HEX digit alternates between its score glyph and 7'b1111111 every BLINK_CYCLES cycles. The glyph is shown first. The loser's digit stays static. The blink counter is cleared by Reset and on entry to MATCH_OVER.
- Undefined: both digits are static and no blink counter is instantiated.

Decomposition:
- Package tow_pkg holds:
  - typedef enum logic [1:0] {PLAY, HOLD, MATCH_OVER} tow_state_e;
  - constants SEG_OFF = 7'b1111111;
  - constant array SEG_DIGIT[0:9] of active-low glyphs;
  - winner codes WIN_NONE, WIN_P1, WIN_P2.
- Sub-module seg7_digit: purely combinational 4-bit to 7-bit active-low decoder, instantiated twice.
- Score and FSM logic stay in tow_match_scoreboard.

Test Plan:
1. Reset: assert Reset for 2 cycles with random inputs -> HEX_L = HEX_R = 7'b1000000, round_reset = 0, winner = 00, match_over = 0.
2. Left round win (WIN_TARGET=3, HOLD_CYCLES=4): lightLeft=1, pulse L -> next edge HEX_L = "1" (7'b1111001) and round_reset high for exactly 4 cycles. Stimulus during the hold is ignored. The block then returns to PLAY.
3. Non-win inputs:
   - L&R pulsed with both lights on -> no score change.
   - R with only lightLeft on -> no score change.
4. Match: right wins 3 rounds -> HEX_R = "3" (7'b0110000), winner = 01, match_over = 1, round_reset stays high.
   - Further L/R/light stimulus for 20 cycles changes nothing.
5. Reset mid-operation: assert Reset during the 2nd HOLD cycle -> all outputs return to reset values on the next edge. A new win is scored normally afterwards.
6. With TOW_BLINK_WINNER_EN (BLINK_CYCLES=2): left wins the match -> HEX_L alternates glyph/7'b1111111 every 2 cycles, starting with the glyph. HEX_R stays static.
